// File: rtl/llsc_atomic_unit_pkg.sv
// llsc_atomic_unit_pkg
//   Shared definitions for the LL/SC atomic unit: FSM state encoding,
//   atomic op code and the default link granule size.
package llsc_atomic_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MREQ  = 3'd1,
        ST_MWAIT = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    typedef enum logic {
        OP_LL = 1'b0,
        OP_SC = 1'b1
    } op_t;

    // 16-byte link granule: low 4 address bits ignored in link compares.
    localparam int LINK_GRAN_DEF = 4;

endpackage

// File: rtl/llsc_link_tracker.sv
// llsc_link_tracker
//   Holds LLbit and the link granule address. Applies the set/clear priority
//   (clear beats set) and performs the snoop and SC link compares.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   flush, ertn_clr  immediate link clears
//   snoop_valid      snooped store present; snoop_gran is its granule
//   sc_clr           SC accepted this cycle (always clears LLbit)
//   set_en/set_gran  LL response: set LLbit and record granule
//   chk_gran         granule of the incoming request, compared to the link
//   llbit            current LLbit
//   chk_hit          pre-snoop link match for chk_gran
//   clr_now          a clear source is active this cycle
module llsc_link_tracker #(
    parameter int GW = 28
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          ertn_clr,
    input  logic          snoop_valid,
    input  logic [GW-1:0] snoop_gran,
    input  logic          sc_clr,
    input  logic          set_en,
    input  logic [GW-1:0] set_gran,
    input  logic [GW-1:0] chk_gran,
    output logic          llbit,
    output logic          chk_hit,
    output logic          clr_now
);

    logic [GW-1:0] link_addr;
    logic          snoop_hit;

    assign snoop_hit = snoop_valid && llbit && (snoop_gran == link_addr);
    assign clr_now   = flush || ertn_clr || snoop_hit;
    assign chk_hit   = llbit && (chk_gran == link_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            llbit     <= 1'b0;
            link_addr <= '0;
        end else if (clr_now || sc_clr) begin
            llbit     <= 1'b0;
        end else if (set_en) begin
            llbit     <= 1'b1;
            link_addr <= set_gran;
        end
    end

endmodule

// File: rtl/llsc_atomic_unit.sv
// llsc_atomic_unit
//   Execution side of the LL/SC link: accepts LL/SC requests, issues the
//   cache access, owns LLbit via llsc_link_tracker and returns LL data or
//   the SC success flag to writeback.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   flush, ertn_clr              pipeline flush, ERTN link clear
//   req_*                        atomic request handshake from MEM stage
//   snoop_valid, snoop_addr      foreign / non-SC store observed
//   mem_req_*, mem_resp_*        data-cache port
//   resp_valid, resp_data        one-cycle result to writeback
//   llbit_o                      current LLbit
module llsc_atomic_unit
    import llsc_atomic_unit_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LINK_GRAN = LINK_GRAN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ertn_clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_sc,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              llbit_o
);

    localparam int GW = ADDR_W - LINK_GRAN;

    state_t            state;
    op_t               op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;

    logic accept;
    logic sc_ok;
    logic set_en;
    logic chk_hit;
    logic clr_now;
    logic unused_snoop_low;

    assign unused_snoop_low = ^snoop_addr[LINK_GRAN-1:0];

    // A flush in the acceptance cycle squashes the incoming request.
    assign accept = req_valid && (state == ST_IDLE) && !flush;
    // Link match is taken before the same-cycle clear, but any clear
    // active at acceptance still makes the SC fail.
    assign sc_ok  = chk_hit && !clr_now;
    assign set_en = (state == ST_MWAIT) && mem_resp_valid && (op_r == OP_LL) && !flush;

    llsc_link_tracker #(
        .GW (GW)
    ) u_link (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .ertn_clr    (ertn_clr),
        .snoop_valid (snoop_valid),
        .snoop_gran  (snoop_addr[ADDR_W-1:LINK_GRAN]),
        .sc_clr      (accept && req_is_sc),
        .set_en      (set_en),
        .set_gran    (addr_r[ADDR_W-1:LINK_GRAN]),
        .chk_gran    (req_addr[ADDR_W-1:LINK_GRAN]),
        .llbit       (llbit_o),
        .chk_hit     (chk_hit),
        .clr_now     (clr_now)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_r      <= OP_LL;
            addr_r    <= '0;
            wdata_r   <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_r    <= req_is_sc ? OP_SC : OP_LL;
                        addr_r  <= req_addr;
                        wdata_r <= req_wdata;
                        if (!req_is_sc || sc_ok) begin
                            state <= ST_MREQ;
                        end else begin
                            resp_data <= '0;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_MREQ: begin
                    // Once the cache has taken the request its response
                    // must still be absorbed, so a coincident flush drains.
                    if (mem_req_ready) begin
                        state <= flush ? ST_DRAIN : ST_MWAIT;
                    end else if (flush) begin
                        state <= ST_IDLE;
                    end
                end
                ST_MWAIT: begin
                    if (mem_resp_valid) begin
                        if (flush) begin
                            state <= ST_IDLE;
                        end else begin
                            resp_data <= (op_r == OP_SC) ? {{(DATA_W-1){1'b0}}, 1'b1}
                                                         : mem_resp_rdata;
                            state     <= ST_RESP;
                        end
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (mem_resp_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = (state == ST_IDLE);
    assign mem_req_valid = (state == ST_MREQ);
    assign mem_req_we    = (op_r == OP_SC);
    assign mem_req_addr  = addr_r;
    assign mem_req_wdata = wdata_r;
    assign resp_valid    = (state == ST_RESP) && !flush;

endmodule
